// File: rtl/ppheavy_drive_seq_if.sv
// Control and status bundle between the heavy-pump on-timer and the drive sequencer.
// master: on-timer side (drives enable/start); slave: sequencer side (drives status).
// All signals are synchronous to clk_10k.
interface ppheavy_drive_seq_if;
    logic       enable;
    logic       start;
    logic       drive;
    logic       busy;
    logic [3:0] pulse_cnt;
    logic       done;
    logic       overrun;

    modport master (
        output enable,
        output start,
        input  drive,
        input  busy,
        input  pulse_cnt,
        input  done,
        input  overrun
    );

    modport slave (
        input  enable,
        input  start,
        output drive,
        output busy,
        output pulse_cnt,
        output done,
        output overrun
    );
endinterface

// File: rtl/ppheavy_drive_seq.sv
// Turns accepted start strobes into fixed-width pump drive pulses, each followed by an off-time guard.
// Latency: drive rises on the accepting edge; done/pulse_cnt update on the edge drive falls.
// No backpressure: strobes arriving during a pulse or guard are dropped and flagged as overrun.
module ppheavy_drive_seq #(
    parameter int ON_CYCLES      = 8,
    parameter int GUARD_CYCLES   = 4,
    parameter int PULSES_PER_SEQ = 2
) (
    input logic                clk_10k,
    input logic                rst_n,
    ppheavy_drive_seq_if.slave bus
);

    // The shared timer is loaded with N-1 and runs down to 0, so a phase spans exactly N edges.
    localparam logic [5:0] ON_LOAD    = 6'(ON_CYCLES - 1);
    localparam logic [5:0] GUARD_LOAD = 6'(GUARD_CYCLES - 1);
    // Count value on which the next completed pulse closes the sequence.
    localparam logic [3:0] SEQ_LAST   = 4'(PULSES_PER_SEQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] timer;
    logic       drive_q;
    logic       busy_q;
    logic [3:0] cnt_q;
    logic       done_q;
    logic       overrun_q;

    // Sequencer FSM with all outputs registered; enable low wins over everything else.
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= 6'd0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                timer     <= 6'd0;
                drive_q   <= 1'b0;
                busy_q    <= 1'b0;
                cnt_q     <= 4'd0;
                overrun_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state   <= DRIVE;
                            timer   <= ON_LOAD;
                            drive_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end

                    DRIVE: begin
                        // Strobes during the pulse never retrigger or stretch it.
                        if (bus.start) begin
                            overrun_q <= 1'b1;
                        end
                        if (timer == 6'd0) begin
                            state   <= GUARD;
                            timer   <= GUARD_LOAD;
                            drive_q <= 1'b0;
                            if (cnt_q == SEQ_LAST) begin
                                cnt_q  <= 4'd0;
                                done_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end else begin
                            timer <= timer - 6'd1;
                        end
                    end

                    GUARD: begin
                        if (timer == 6'd0) begin
                            // Guard has fully elapsed on this edge, so a strobe here
                            // starts the next pulse directly (edge k+ON+GUARD).
                            if (bus.start) begin
                                state   <= DRIVE;
                                timer   <= ON_LOAD;
                                drive_q <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            timer <= timer - 6'd1;
                            if (bus.start) begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        timer   <= 6'd0;
                        drive_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.drive     = drive_q;
    assign bus.busy      = busy_q;
    assign bus.pulse_cnt = cnt_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

endmodule
